// File: rtl/fifo_ptr_pkg.sv
// Shared types and Gray-code helpers for the async FIFO pointer generators.
package fifo_ptr_pkg;

  typedef enum logic {
    PTR_WRITE = 1'b0,
    PTR_READ  = 1'b1
  } ptr_mode_t;

  localparam int unsigned PTR_MAXW = 32;

  function automatic logic [PTR_MAXW-1:0] ptr_mask(input int unsigned w);
    if (w >= PTR_MAXW) return '1;
    return (PTR_MAXW'(1) << w) - PTR_MAXW'(1);
  endfunction

  function automatic logic [PTR_MAXW-1:0] bin2gray(input logic [PTR_MAXW-1:0] b,
                                                   input int unsigned w);
    logic [PTR_MAXW-1:0] bm;
    bm = b & ptr_mask(w);
    return bm ^ (bm >> 1);
  endfunction

  // Bits above w are treated as zero, so the prefix XOR starts at bit w-1.
  function automatic logic [PTR_MAXW-1:0] gray2bin(input logic [PTR_MAXW-1:0] g,
                                                   input int unsigned w);
    logic [PTR_MAXW-1:0] gm;
    logic [PTR_MAXW-1:0] b;
    logic acc;
    gm  = g & ptr_mask(w);
    b   = '0;
    acc = 1'b0;
    for (int i = PTR_MAXW - 1; i >= 0; i--) begin
      acc  = acc ^ gm[i];
      b[i] = acc;
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter (prefix XOR from the MSB down).
module gray_to_bin #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  logic acc;

  always_comb begin
    acc = 1'b0;
    bin = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc    = acc ^ gray[i];
      bin[i] = acc;
    end
  end

endmodule

// File: rtl/fifo_ptr_gen.sv
// Binary/Gray pointer with registered full (write mode) or empty (read mode) flag.
// Define FIFO_PTR_ALMOST_EN to add the registered almost-full/almost-empty output.
module fifo_ptr_gen
  import fifo_ptr_pkg::*;
#(
  parameter int        ADDR_WIDTH    = 5,
  parameter ptr_mode_t MODE          = PTR_WRITE,
  parameter int        ALMOST_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  input  logic [ADDR_WIDTH:0]   peer_gray,
  output logic                  accept,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_WIDTH:0]   bin_ptr,
  output logic [ADDR_WIDTH:0]   gray_ptr,
`ifdef FIFO_PTR_ALMOST_EN
  output logic                  almost,
`endif
  output logic                  flag
);

  localparam int PW = ADDR_WIDTH + 1;

  if (ADDR_WIDTH < 2 || ALMOST_THRESH < 0 || ALMOST_THRESH > (1 << ADDR_WIDTH)) begin : g_bad_cfg
    $error("fifo_ptr_gen: unsupported ADDR_WIDTH/ALMOST_THRESH combination");
  end

  logic                adv;
  logic [ADDR_WIDTH:0] bin_next;
  logic [ADDR_WIDTH:0] gray_next;
  logic                flag_next;

  // Full compares against the peer pointer one lap ahead (top two Gray bits flipped).
  always_comb begin
    adv       = inc & ~flag;
    bin_next  = bin_ptr + {{ADDR_WIDTH{1'b0}}, adv};
    gray_next = PW'(bin2gray({{(PTR_MAXW - PW){1'b0}}, bin_next}, PW));
    if (MODE == PTR_WRITE)
      flag_next = (gray_next == {~peer_gray[ADDR_WIDTH:ADDR_WIDTH-1], peer_gray[ADDR_WIDTH-2:0]});
    else
      flag_next = (gray_next == peer_gray);
  end

  assign accept = adv;
  assign addr   = bin_ptr[ADDR_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_ptr  <= '0;
      gray_ptr <= '0;
      flag     <= (MODE == PTR_READ);
    end else begin
      bin_ptr  <= bin_next;
      gray_ptr <= gray_next;
      flag     <= flag_next;
    end
  end

`ifdef FIFO_PTR_ALMOST_EN
  logic [ADDR_WIDTH:0] peer_bin;
  logic [ADDR_WIDTH:0] distance;
  logic                almost_next;

  gray_to_bin #(.WIDTH(PW)) u_peer_g2b (
    .gray (peer_gray),
    .bin  (peer_bin)
  );

  // Write mode measures occupancy; read mode measures entries left to pop.
  always_comb begin
    if (MODE == PTR_WRITE) begin
      distance    = bin_next - peer_bin;
      almost_next = (int'(distance) >= ((1 << ADDR_WIDTH) - ALMOST_THRESH));
    end else begin
      distance    = peer_bin - bin_next;
      almost_next = (int'(distance) <= ALMOST_THRESH);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      almost <= (MODE == PTR_READ);
    else
      almost <= almost_next;
  end
`endif

endmodule

// File: tb/tb_fifo_ptr_gen.sv
// Randomised and directed check of write- and read-mode fifo_ptr_gen against a
// modular-count reference model.
module tb_fifo_ptr_gen;
  import fifo_ptr_pkg::*;

  localparam int AW    = 5;
  localparam int SPAN  = 64;
  localparam int DEPTH = 32;
  localparam int THR   = 2;

  logic          clk = 1'b0;
  logic          rst_w, rst_r, w_inc, r_inc;
  logic [AW:0]   w_peer_gray, r_peer_gray;
  logic          w_accept, r_accept, w_flag, r_flag;
  logic [AW-1:0] w_addr, r_addr;
  logic [AW:0]   w_bin, w_gray, r_bin, r_gray;
`ifdef FIFO_PTR_ALMOST_EN
  logic          w_almost, r_almost;
`endif

  int checks = 0;
  int failures = 0;

  int w_ptr, w_peer, r_ptr, r_peer;
  logic exp_w_flag, exp_r_flag, exp_w_almost, exp_r_almost;

  always #5 clk = ~clk;

  fifo_ptr_gen #(.ADDR_WIDTH(AW), .MODE(PTR_WRITE), .ALMOST_THRESH(THR)) dut_w (
    .clk(clk), .rst(rst_w), .inc(w_inc), .peer_gray(w_peer_gray),
    .accept(w_accept), .addr(w_addr), .bin_ptr(w_bin), .gray_ptr(w_gray),
`ifdef FIFO_PTR_ALMOST_EN
    .almost(w_almost),
`endif
    .flag(w_flag)
  );

  fifo_ptr_gen #(.ADDR_WIDTH(AW), .MODE(PTR_READ), .ALMOST_THRESH(THR)) dut_r (
    .clk(clk), .rst(rst_r), .inc(r_inc), .peer_gray(r_peer_gray),
    .accept(r_accept), .addr(r_addr), .bin_ptr(r_bin), .gray_ptr(r_gray),
`ifdef FIFO_PTR_ALMOST_EN
    .almost(r_almost),
`endif
    .flag(r_flag)
  );

  function automatic logic [AW:0] to_gray(input int v);
    logic [AW:0] b;
    b = (AW+1)'(v);
    return b ^ (b >> 1);
  endfunction

  function automatic int wrap(input int v);
    return ((v % SPAN) + SPAN) % SPAN;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, check accept, clock, advance model, check registers.
  task automatic applyStimulus(input logic rw, input logic wi, input logic rr, input logic ri);
    logic [AW:0] prev_wg, prev_rg;
    int prev_wp, prev_rp;
    rst_w = rw; w_inc = wi; w_peer_gray = to_gray(w_peer);
    rst_r = rr; r_inc = ri; r_peer_gray = to_gray(r_peer);
    #1;
    checkOutput("w_accept", 32'(w_accept), 32'(wi & ~exp_w_flag));
    checkOutput("r_accept", 32'(r_accept), 32'(ri & ~exp_r_flag));
    prev_wg = w_gray; prev_rg = r_gray; prev_wp = w_ptr; prev_rp = r_ptr;
    @(posedge clk);
    #1;
    if (rw) begin
      w_ptr = 0; exp_w_flag = 1'b0; exp_w_almost = 1'b0;
    end else begin
      if (wi && !exp_w_flag) w_ptr = wrap(w_ptr + 1);
      exp_w_flag   = (wrap(w_ptr - w_peer) == DEPTH);
      exp_w_almost = (wrap(w_ptr - w_peer) >= DEPTH - THR);
    end
    if (rr) begin
      r_ptr = 0; exp_r_flag = 1'b1; exp_r_almost = 1'b1;
    end else begin
      if (ri && !exp_r_flag) r_ptr = wrap(r_ptr + 1);
      exp_r_flag   = (r_ptr == r_peer);
      exp_r_almost = (wrap(r_peer - r_ptr) <= THR);
    end
    checkOutput("w_bin",  32'(w_bin),  32'(w_ptr));
    checkOutput("w_gray", 32'(w_gray), 32'(to_gray(w_ptr)));
    checkOutput("w_addr", 32'(w_addr), 32'(w_ptr % DEPTH));
    checkOutput("w_flag", 32'(w_flag), 32'(exp_w_flag));
    checkOutput("r_bin",  32'(r_bin),  32'(r_ptr));
    checkOutput("r_gray", 32'(r_gray), 32'(to_gray(r_ptr)));
    checkOutput("r_addr", 32'(r_addr), 32'(r_ptr % DEPTH));
    checkOutput("r_flag", 32'(r_flag), 32'(exp_r_flag));
`ifdef FIFO_PTR_ALMOST_EN
    checkOutput("w_almost", 32'(w_almost), 32'(exp_w_almost));
    checkOutput("r_almost", 32'(r_almost), 32'(exp_r_almost));
`endif
    if (!rw) checkOutput("w_gray_step", 32'($countones(w_gray ^ prev_wg)), 32'(w_ptr != prev_wp));
    if (!rr) checkOutput("r_gray_step", 32'($countones(r_gray ^ prev_rg)), 32'(r_ptr != prev_rp));
  endtask

  initial begin
    int pops;
    w_ptr = 0; w_peer = 0; r_ptr = 0; r_peer = 0;
    rst_w = 1'b1; rst_r = 1'b1; w_inc = 1'b0; r_inc = 1'b0;
    w_peer_gray = '0; r_peer_gray = '0;
    @(posedge clk);
    #1;
    exp_w_flag = 1'b0; exp_w_almost = 1'b0; exp_r_flag = 1'b1; exp_r_almost = 1'b1;

    // Reset held two cycles with requests pending
    repeat (2) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("rst_w_flag", 32'(w_flag), 32'd0);
    checkOutput("rst_r_flag", 32'(r_flag), 32'd1);
    checkOutput("rst_w_bin", 32'(w_bin), 32'd0);

    // Fill to full
    repeat (33) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("fill_bin", 32'(w_bin), 32'h20);
    checkOutput("fill_gray", 32'(w_gray), 32'h30);
    checkOutput("fill_flag", 32'(w_flag), 32'd1);

    // Drain to empty, then peer advance clears empty
    r_peer = 3;
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("drain_bin", 32'(r_bin), 32'd3);
    checkOutput("drain_flag", 32'(r_flag), 32'd1);
    r_peer = 4;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("drain_clear", 32'(r_flag), 32'd0);

    // Read pointer wrap-around over 64 pops
    r_peer = 0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    pops = 0;
    for (int i = 0; i < 200 && pops < 64; i++) begin
      r_peer = wrap(r_ptr + 2);
      if (!exp_r_flag) pops++;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    end
    checkOutput("wrap_pops", 32'(pops), 32'd64);
    checkOutput("wrap_bin", 32'(r_bin), 32'd0);
    checkOutput("wrap_gray", 32'(r_gray), 32'd0);

    // Reset mid-run in write mode
    w_peer = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (17) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("mid_bin17", 32'(w_bin), 32'd17);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("mid_rst_bin", 32'(w_bin), 32'd0);
    checkOutput("mid_rst_flag", 32'(w_flag), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("mid_resume", 32'(w_bin), 32'd1);

`ifdef FIFO_PTR_ALMOST_EN
    // Almost-full threshold
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (30) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("almost_30", 32'(w_almost), 32'd1);
    checkOutput("almost_flag30", 32'(w_flag), 32'd0);
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("almost_flag32", 32'(w_flag), 32'd1);
`endif

    // Random traffic with peers moving like the opposite domain would
    for (int i = 0; i < 600; i++) begin
      logic rw, rr, wi, ri;
      rw = ($urandom_range(0, 63) == 0);
      rr = ($urandom_range(0, 63) == 0);
      wi = ($urandom_range(0, 3) != 0);
      ri = ($urandom_range(0, 3) != 0);
      if (w_peer != w_ptr && $urandom_range(0, 1) == 1) w_peer = wrap(w_peer + 1);
      if (wrap(r_peer - r_ptr) < DEPTH && $urandom_range(0, 1) == 1) r_peer = wrap(r_peer + 1);
      if (rw) w_peer = 0;
      if (rr) r_peer = 0;
      applyStimulus(rw, wi, rr, ri);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
